// File: rtl/barcode_entry_if.sv
// barcode_entry_if: key/switch inputs and barcode shift-register controls of barcode_entry_controller
interface barcode_entry_if;
    logic       key_enter_n_i;
    logic       key_clear_n_i;
    logic [3:0] sw_digit_i;
    logic       consumed_i;
    logic [3:0] digit_o;
    logic       shift_en_o;
    logic       shift_reset_n_o;
    logic [2:0] digit_count_o;
    logic       barcode_ready_o;
    logic       error_o;
    modport slave (
        input  key_enter_n_i, key_clear_n_i, sw_digit_i, consumed_i,
        output digit_o, shift_en_o, shift_reset_n_o, digit_count_o, barcode_ready_o, error_o
    );
    modport master (
        output key_enter_n_i, key_clear_n_i, sw_digit_i, consumed_i,
        input  digit_o, shift_en_o, shift_reset_n_o, digit_count_o, barcode_ready_o, error_o
    );
endinterface

// File: rtl/barcode_entry_controller.sv
// barcode_entry_controller: debounced enter/clear keys build a 4-digit barcode in a downstream shift register
module barcode_entry_controller #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [3:0] BLANK_CODE      = 4'd12
) (
    input logic             clk,
    input logic             rst_n,
    barcode_entry_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    typedef enum logic [1:0] {COLLECT, FULL, CLEAR} state_t;
    logic [1:0] keys_n;
    logic [1:0] press;
    assign keys_n = {bus.key_clear_n_i, bus.key_enter_n_i};
    genvar k;
    for (k = 0; k < 2; k++) begin : g_key
        logic [1:0]    sync_q;
        logic          deb_q, deb_d, fall_q;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          done;
        assign done     = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
        assign press[k] = fall_q;
        // any cycle that agrees with the debounced level restarts the count
        always_comb begin
            deb_d = deb_q;
            cnt_d = '0;
            if (sync_q[1] != deb_q) begin
                cnt_d = done ? '0 : cnt_q + CW'(1);
                deb_d = done ? sync_q[1] : deb_q;
            end
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= 2'b11;
                deb_q  <= 1'b1;
                cnt_q  <= '0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[0], keys_n[k]};
                deb_q  <= deb_d;
                cnt_q  <= cnt_d;
                fall_q <= deb_q & ~deb_d;
            end
        end
    end
    state_t     state_q, state_d;
    logic [3:0] digit_q, digit_d;
    logic [2:0] count_q, count_d;
    logic       shift_q, shift_d, ready_q, ready_d, err_q, err_d, go_clr;
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        count_d = count_q;
        err_d   = err_q;
        shift_d = 1'b0;
        go_clr  = press[1] | (state_q == FULL && bus.consumed_i);
        if (go_clr) begin
            state_d = CLEAR;
            digit_d = BLANK_CODE;
            count_d = '0;
            err_d   = 1'b0;
        end else if (state_q == CLEAR) begin
            state_d = COLLECT;
        end else if (state_q == COLLECT && press[0]) begin
            if (bus.sw_digit_i <= 4'd9) begin
                digit_d = bus.sw_digit_i;
                shift_d = 1'b1;
                count_d = count_q + 3'd1;
                err_d   = 1'b0;
                state_d = count_q == 3'd3 ? FULL : COLLECT;
            end else begin
                err_d = 1'b1;
            end
        end
        // FULL is entered with the last shift, so ready follows one cycle later
        ready_d = state_q == FULL && !go_clr;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            digit_q <= BLANK_CODE;
            count_q <= '0;
            shift_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            count_q <= count_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end
    assign bus.digit_o         = digit_q;
    assign bus.shift_en_o      = shift_q;
    assign bus.shift_reset_n_o = state_q != CLEAR;
    assign bus.digit_count_o   = count_q;
    assign bus.barcode_ready_o = ready_q;
    assign bus.error_o         = err_q;
endmodule

// File: tb/tb_barcode_entry_controller.sv
// tb_barcode_entry_controller: random key presses against a digit-list model, scoreboarded shift/clear pulses
module tb_barcode_entry_controller;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    barcode_entry_if bus();
    barcode_entry_controller #(.DEBOUNCE_CYCLES(D), .BLANK_CODE(4'd12)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    typedef struct {bit clr; logic [3:0] d; logic [2:0] c;} ev_t;
    ev_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int m_count;
    bit m_err, m_full;
    logic [3:0] m_digit;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    // monitor: every shift or clear pulse must match the oldest expected event
    always @(negedge clk) begin
        if (rst_n && (bus.shift_en_o || !bus.shift_reset_n_o)) begin : mon
            ev_t e;
            chk("shift_and_reset_together", {31'd0, bus.shift_en_o & ~bus.shift_reset_n_o}, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind_clear", {31'd0, ~bus.shift_reset_n_o}, {31'd0, e.clr});
                chk("pulse_digit", {28'd0, bus.digit_o}, {28'd0, e.d});
                chk("pulse_count", {29'd0, bus.digit_count_o}, {29'd0, e.c});
            end
        end
    end
    task automatic m_reset();
        m_count = 0; m_err = 0; m_full = 0; m_digit = 4'd12;
    endtask
    task automatic m_clear();
        m_reset();
        exp_q.push_back('{1'b1, 4'd12, 3'd0});
    endtask
    task automatic m_enter(input logic [3:0] d);
        if (!m_full) begin
            if (d > 9) m_err = 1;
            else begin
                m_count++;
                m_digit = d;
                m_err = 0;
                exp_q.push_back('{1'b0, d, 3'(m_count)});
                if (m_count == 4) m_full = 1;
            end
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic press(input bit ent, input bit clr, input logic [3:0] d, input int bounces);
        if (clr) m_clear();
        else if (ent) m_enter(d);
        bus.sw_digit_i = d;
        for (int b = 0; b < bounces; b++) begin
            bus.key_enter_n_i = ~ent; bus.key_clear_n_i = ~clr;
            cyc(2);
            bus.key_enter_n_i = 1'b1; bus.key_clear_n_i = 1'b1;
            cyc(2);
        end
        bus.key_enter_n_i = ~ent; bus.key_clear_n_i = ~clr;
        cyc(D + 6);
        bus.key_enter_n_i = 1'b1; bus.key_clear_n_i = 1'b1;
        cyc(D + 6);
    endtask
    task automatic consume();
        if (m_full) m_clear();
        bus.consumed_i = 1'b1;
        cyc(1);
        bus.consumed_i = 1'b0;
        cyc(4);
    endtask
    task automatic check_state(input string tag);
        chk({tag, "_count"}, {29'd0, bus.digit_count_o}, m_count);
        chk({tag, "_error"}, {31'd0, bus.error_o}, {31'd0, m_err});
        chk({tag, "_ready"}, {31'd0, bus.barcode_ready_o}, {31'd0, m_full});
        chk({tag, "_digit"}, {28'd0, bus.digit_o}, {28'd0, m_digit});
    endtask
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_digit"}, {28'd0, bus.digit_o}, 12);
        chk({tag, "_shift_en"}, {31'd0, bus.shift_en_o}, 0);
        chk({tag, "_shift_reset_n"}, {31'd0, bus.shift_reset_n_o}, 1);
        chk({tag, "_count"}, {29'd0, bus.digit_count_o}, 0);
        chk({tag, "_ready"}, {31'd0, bus.barcode_ready_o}, 0);
        chk({tag, "_error"}, {31'd0, bus.error_o}, 0);
    endtask
    initial begin
        bus.key_enter_n_i = 1'b1; bus.key_clear_n_i = 1'b1;
        bus.sw_digit_i = 4'd0; bus.consumed_i = 1'b0;
        m_reset();
        cyc(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc(2);
        press(1, 0, 4'd7, 3);
        check_state("bounced_enter");
        press(0, 1, 4'd0, 0);
        check_state("clear_key");
        for (int i = 1; i <= 4; i++) press(1, 0, 4'(i), 0);
        check_state("full");
        press(1, 0, 4'd5, 0);
        check_state("enter_in_full");
        press(1, 0, 4'd11, 0);
        check_state("bad_enter_in_full");
        consume();
        check_state("consumed");
        press(1, 0, 4'd11, 0);
        check_state("bad_digit");
        press(1, 0, 4'd3, 0);
        check_state("good_after_bad");
        consume();
        check_state("consume_not_full");
        press(1, 0, 4'd4, 1);
        press(1, 1, 4'd9, 0);
        check_state("enter_clear_same");
        for (int i = 0; i < 40; i++) begin
            int r = $urandom_range(0, 9);
            if (r <= 5) press(1, 0, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
            else if (r == 6) press(0, 1, 4'd0, 0);
            else if (r == 8) press(1, 1, 4'($urandom_range(0, 15)), 0);
            else consume();
            check_state("random");
        end
        press(0, 1, 4'd0, 0);
        for (int i = 0; i < 3; i++) press(1, 0, 4'(i + 6), 0);
        check_state("before_async_reset");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        m_reset();
        chk("queue_empty_at_reset", exp_q.size(), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        bus.sw_digit_i = 4'd5;
        bus.key_enter_n_i = 1'b0;
        #2 rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        m_enter(4'd5);
        cyc(D + 8);
        bus.key_enter_n_i = 1'b1;
        cyc(D + 6);
        check_state("held_through_reset");
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) cyc(1);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/barcode_entry_controller.md
BARCODE_ENTRY_CONTROLLER -- requirements
Module: barcode_entry_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter BLANK_CODE, default 12, is the digit code a cleared barcode position holds.
REQ-003 CLOCK  in  1  single clock (CLOCK_50); all logic on rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 KEY_ENTER_N  in  1  raw active-low pushbutton, asynchronous to CLOCK, bouncy; press = enter digit.
REQ-006 KEY_CLEAR_N  in  1  raw active-low pushbutton, asynchronous, bouncy; press = abort/clear entry.
REQ-007 SW_DIGIT  in  4  switch value, sampled on the accepted enter event.
REQ-008 CONSUMED  in  1  one-cycle pulse from downstream; the completed barcode has been taken.
REQ-009 Digit_out  out  4  digit presented to the barcode shift register.
REQ-010 SHIFT_EN  out  1  one-cycle pulse; shift Digit_out into the barcode register.
REQ-011 SHIFT_RESET_N  out  1  one-cycle active-low pulse; reset the barcode register to BLANK_CODE.
REQ-012 DIGIT_COUNT  out  3  digits accepted in the current barcode, 0..4.
REQ-013 BARCODE_READY  out  1  high while 4 valid digits are held.
REQ-014 ERROR  out  1  sticky flag; last enter attempt had SW_DIGIT > 9.

Function
REQ-015 Each key passes through a 2-flop synchronizer, then a debouncer; the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the counter at 0.
REQ-016 A press event is a 1-to-0 transition of the debounced level, one cycle wide; releases generate no event; a held key generates exactly one event.
REQ-017 Event latency: a key stable low from cycle 0 gives an event in cycle 2+DEBOUNCE_CYCLES (±1); the response outputs update on the following edge.
REQ-018 FSM states: COLLECT, FULL, CLEAR; reset state COLLECT.
REQ-019 COLLECT, enter event, SW_DIGIT <= 9: Digit_out <= SW_DIGIT, SHIFT_EN = 1 for exactly one cycle with Digit_out already valid in that cycle, DIGIT_COUNT += 1, ERROR <= 0.
REQ-020 COLLECT, enter event, SW_DIGIT in 10..15: no SHIFT_EN, DIGIT_COUNT unchanged, Digit_out unchanged, ERROR <= 1.
REQ-021 When a valid enter makes DIGIT_COUNT 4, go to FULL in the same cycle as the SHIFT_EN pulse; BARCODE_READY = 1 from the next cycle.
REQ-022 FULL: enter events are ignored (no shift, no ERROR change); CONSUMED = 1 goes to CLEAR.
REQ-023 Clear event in any state, or CONSUMED in FULL: go to CLEAR.
REQ-024 CLEAR lasts exactly one cycle: SHIFT_RESET_N = 0, DIGIT_COUNT <= 0, BARCODE_READY <= 0, ERROR <= 0, Digit_out <= BLANK_CODE; next state COLLECT.
REQ-025 Simultaneous events: a clear event beats an enter event; a clear beats CONSUMED (one CLEAR cycle only); CONSUMED outside FULL is ignored.
REQ-026 SHIFT_EN and SHIFT_RESET_N are never active in the same cycle; at most one SHIFT_EN per press event.
REQ-027 DIGIT_COUNT never exceeds 4 and never wraps.

Reset
REQ-028 While RESET_N = 0: Digit_out = BLANK_CODE, SHIFT_EN = 0, SHIFT_RESET_N = 1, DIGIT_COUNT = 0, BARCODE_READY = 0, ERROR = 0, state COLLECT, synchronizer flops and debounced levels = 1, debounce counters = 0.
REQ-029 Reset mid-entry or in FULL discards all progress with no SHIFT_EN or SHIFT_RESET_N pulse; a key held low through reset release gives one press event after the debounce time.

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 SW_DIGIT=7, KEY_ENTER_N low with 3 bounces of 2 cycles, then stable -> exactly one SHIFT_EN, Digit_out=7, DIGIT_COUNT=1, ERROR=0.
REQ-031 Enter 1,2,3,4 -> four SHIFT_EN pulses with Digit_out 1,2,3,4; BARCODE_READY=1, DIGIT_COUNT=4; fifth enter with SW_DIGIT=5 -> no SHIFT_EN.
REQ-032 From FULL, CONSUMED pulse -> one cycle SHIFT_RESET_N=0, then DIGIT_COUNT=0, BARCODE_READY=0, Digit_out=12.
REQ-033 SW_DIGIT=11 enter -> ERROR=1, no SHIFT_EN, count unchanged; then SW_DIGIT=3 enter -> ERROR=0, SHIFT_EN, Digit_out=3.
REQ-034 Enter and clear events in the same cycle with DIGIT_COUNT=2 -> no SHIFT_EN, SHIFT_RESET_N pulse, DIGIT_COUNT=0.
REQ-035 RESET_N asserted asynchronously with DIGIT_COUNT=3 -> all outputs at their REQ-028 values immediately, without waiting for a clock edge.
